bpu_btb_assoc: RTL and testbench

//  Parametrised set-associative BTB with a per-entry 2-bit BHT counter, in the frontend next to PC generation.

---
 rtl/bpu_btb_assoc.sv | 184 ++++++++++++++++++
 tb/tb_bpu_btb_assoc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb_assoc.sv
// Set-associative BTB with per-entry 2-bit direction counter, write-first lookup and post-reset init sweep.
// Optional performance counters are enabled by defining BPU_BTB_PERF_EN.
module bpu_btb_assoc #(
  parameter int PC_WIDTH    = 64,
  parameter int OFFSET_BITS = 2,
  parameter int SET_BITS    = 8,
  parameter int WAYS        = 2,
  parameter int TAG_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                pc_valid,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target
`ifdef BPU_BTB_PERF_EN
  ,
  output logic [31:0]         perf_lookup,
  output logic [31:0]         perf_hit,
  output logic [31:0]         perf_alloc
`endif
);

  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  // state  | meaning
  // S_INIT | sweeping one set per cycle to invalid, requests ignored
  // S_RUN  | lookups and updates served
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [SET_BITS-1:0] set_cnt;

  logic                valid_q  [NUM_SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q    [NUM_SETS][WAYS];
  logic [1:0]          ctr_q    [NUM_SETS][WAYS];
  logic [PC_WIDTH-1:0] tgt_q    [NUM_SETS][WAYS];
  logic [WAY_BITS-1:0] victim_q [NUM_SETS];

  logic [SET_BITS-1:0] u_idx, l_idx;
  logic [TAG_BITS-1:0] u_tag, l_tag;

  assign u_idx = upd_pc[OFFSET_BITS +: SET_BITS];
  assign u_tag = upd_pc[OFFSET_BITS+SET_BITS +: TAG_BITS];
  assign l_idx = pc[OFFSET_BITS +: SET_BITS];
  assign l_tag = pc[OFFSET_BITS+SET_BITS +: TAG_BITS];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc, upd_pc};

  logic                u_hit, u_inv, u_we, u_alloc, u_adv;
  logic [WAY_BITS-1:0] u_hit_way, u_inv_way, u_way;
  logic [1:0]          u_ctr_old, u_ctr_new;
  logic [PC_WIDTH-1:0] u_tgt_new;

  // Descending scans so the lowest matching / invalid way wins.
  always_comb begin
    u_hit     = 1'b0;
    u_hit_way = '0;
    u_inv     = 1'b0;
    u_inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_BITS'(w);
      end
      if (!valid_q[u_idx][w]) begin
        u_inv     = 1'b1;
        u_inv_way = WAY_BITS'(w);
      end
    end
    u_way     = u_hit ? u_hit_way : (u_inv ? u_inv_way : victim_q[u_idx]);
    u_we      = ready && upd_valid && (u_hit || upd_taken);
    u_alloc   = u_we && !u_hit;
    u_adv     = u_alloc && !u_inv;
    u_ctr_old = ctr_q[u_idx][u_way];
    if (!u_hit)
      u_ctr_new = 2'b10;
    else if (upd_taken)
      u_ctr_new = (u_ctr_old == 2'b11) ? 2'b11 : u_ctr_old + 2'd1;
    else
      u_ctr_new = (u_ctr_old == 2'b00) ? 2'b00 : u_ctr_old - 2'd1;
    u_tgt_new = (u_hit && !upd_taken) ? tgt_q[u_idx][u_way] : upd_target;
  end

  logic                l_hit;
  logic [1:0]          l_ctr;
  logic [PC_WIDTH-1:0] l_tgt;
  logic                e_v;
  logic [TAG_BITS-1:0] e_t;
  logic [1:0]          e_c;
  logic [PC_WIDTH-1:0] e_g;

  // Lookup sees the entry as it will be after this cycle's update (write-first).
  always_comb begin
    l_hit = 1'b0;
    l_ctr = '0;
    l_tgt = '0;
    e_v   = 1'b0;
    e_t   = '0;
    e_c   = '0;
    e_g   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      e_v = valid_q[l_idx][w];
      e_t = tag_q[l_idx][w];
      e_c = ctr_q[l_idx][w];
      e_g = tgt_q[l_idx][w];
      if (u_we && (u_idx == l_idx) && (u_way == WAY_BITS'(w))) begin
        e_v = 1'b1;
        e_t = u_tag;
        e_c = u_ctr_new;
        e_g = u_tgt_new;
      end
      if (e_v && (e_t == l_tag)) begin
        l_hit = 1'b1;
        l_ctr = e_c;
        l_tgt = e_g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      set_cnt     <= '0;
      ready       <= 1'b0;
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
`ifdef BPU_BTB_PERF_EN
      perf_lookup <= '0;
      perf_hit    <= '0;
      perf_alloc  <= '0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          for (int w = 0; w < WAYS; w++)
            valid_q[set_cnt][w] <= 1'b0;
          victim_q[set_cnt] <= '0;
          set_cnt           <= set_cnt + 1'b1;
          pred_valid        <= 1'b0;
          pred_hit          <= 1'b0;
          pred_taken        <= 1'b0;
          pred_target       <= '0;
          if (set_cnt == SET_BITS'(NUM_SETS-1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          pred_valid  <= pc_valid;
          pred_hit    <= pc_valid && l_hit;
          pred_taken  <= pc_valid && l_hit && l_ctr[1];
          pred_target <= (pc_valid && l_hit) ? l_tgt : '0;
          if (u_we) begin
            valid_q[u_idx][u_way] <= 1'b1;
            tag_q[u_idx][u_way]   <= u_tag;
            ctr_q[u_idx][u_way]   <= u_ctr_new;
            tgt_q[u_idx][u_way]   <= u_tgt_new;
            if (u_adv)
              victim_q[u_idx] <= victim_q[u_idx] + WAY_BITS'(1);
          end
`ifdef BPU_BTB_PERF_EN
          perf_lookup <= perf_lookup + 32'(pc_valid);
          perf_hit    <= perf_hit + 32'(pc_valid && l_hit);
          perf_alloc  <= perf_alloc + 32'(u_alloc);
`endif
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_btb_assoc.sv
// Scoreboard bench for bpu_btb_assoc: directed lookups/updates with hand-computed predictions.
module tb_bpu_btb_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        pc_valid;
  logic [63:0] pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid, upd_taken;
  logic [63:0] upd_pc, upd_target;
`ifdef BPU_BTB_PERF_EN
  logic [31:0] perf_lookup, perf_hit, perf_alloc;
`endif

  always #5 clk = ~clk;

  bpu_btb_assoc dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pc_valid(pc_valid), .pc(pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BPU_BTB_PERF_EN
    , .perf_lookup(perf_lookup), .perf_hit(perf_hit), .perf_alloc(perf_alloc)
`endif
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [63:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pred actual=valid required=idle");
      end else begin
        mon_e = sb.pop_front();
        chk("pred_hit", 64'(pred_hit), 64'(mon_e.hit));
        chk("pred_taken", 64'(pred_taken), 64'(mon_e.taken));
        chk("pred_target", pred_target, mon_e.tgt);
      end
    end else if (reset === 1'b0) begin
      chk("idle_zero", 64'({pred_hit, pred_taken, |pred_target}), 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [63:0] a, input logic h, input logic t, input logic [63:0] g);
    pc_valid = 1'b1;
    pc       = a;
    sb.push_back('{h, t, g});
    cyc();
    pc_valid = 1'b0;
  endtask

  task automatic update(input logic [63:0] a, input logic t, input logic [63:0] g);
    upd_valid  = 1'b1;
    upd_pc     = a;
    upd_taken  = t;
    upd_target = g;
    cyc();
    upd_valid  = 1'b0;
  endtask

  task automatic both(input logic [63:0] la, input logic h, input logic t, input logic [63:0] g,
                      input logic [63:0] ua, input logic ut, input logic [63:0] ug);
    pc_valid   = 1'b1;
    pc         = la;
    upd_valid  = 1'b1;
    upd_pc     = ua;
    upd_taken  = ut;
    upd_target = ug;
    sb.push_back('{h, t, g});
    cyc();
    pc_valid   = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      cyc();
      n++;
    end
    chk(name, 64'(n), 64'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_valid = 1'b0; pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    cyc();
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_pred_valid", 64'(pred_valid), 64'd0);
    reset = 1'b0;
    wait_ready("init_cycles");

    // cold lookup misses
    lookup(64'h1234, 1'b0, 1'b0, 64'h0);

    // allocate, then train the counter down and up through both saturation points
    update(64'h1000, 1'b1, 64'h2000);
    lookup(64'h1000, 1'b1, 1'b1, 64'h2000);
    update(64'h1000, 1'b0, 64'hdead);
    lookup(64'h1000, 1'b1, 1'b0, 64'h2000);
    update(64'h1000, 1'b0, 64'hdead);
    update(64'h1000, 1'b0, 64'hdead);
    lookup(64'h1000, 1'b1, 1'b0, 64'h2000);
    update(64'h1000, 1'b1, 64'h2000);
    lookup(64'h1000, 1'b1, 1'b0, 64'h2000);
    update(64'h1000, 1'b1, 64'h2000);
    lookup(64'h1000, 1'b1, 1'b1, 64'h2000);
    update(64'h1000, 1'b1, 64'h2000);
    update(64'h1000, 1'b1, 64'h3000);
    lookup(64'h1000, 1'b1, 1'b1, 64'h3000);
    update(64'h1000, 1'b0, 64'h4444);
    lookup(64'h1000, 1'b1, 1'b1, 64'h3000);

    // offset bits and bits above the tag are ignored
    lookup(64'h1003, 1'b1, 1'b1, 64'h3000);
    lookup(64'h4001000, 1'b1, 1'b1, 64'h3000);

    // set 1 replacement: invalid-first, then round-robin victim
    update(64'h0004, 1'b1, 64'hA0);
    update(64'h0404, 1'b1, 64'hB0);
    update(64'h0804, 1'b1, 64'hC0);
    lookup(64'h0004, 1'b0, 1'b0, 64'h0);
    lookup(64'h0404, 1'b1, 1'b1, 64'hB0);
    lookup(64'h0804, 1'b1, 1'b1, 64'hC0);
    update(64'h0C04, 1'b1, 64'hD0);
    lookup(64'h0404, 1'b0, 1'b0, 64'h0);
    lookup(64'h0C04, 1'b1, 1'b1, 64'hD0);
    update(64'h1404, 1'b0, 64'hF0);
    lookup(64'h1404, 1'b0, 1'b0, 64'h0);
    update(64'h0C04, 1'b1, 64'hD1);
    update(64'h1004, 1'b1, 64'hE0);
    lookup(64'h0804, 1'b0, 1'b0, 64'h0);
    lookup(64'h0C04, 1'b1, 1'b1, 64'hD1);
    lookup(64'h1004, 1'b1, 1'b1, 64'hE0);

    // write-first: counter update and fresh allocation seen in the same cycle
    both(64'h1000, 1'b1, 1'b0, 64'h3000, 64'h1000, 1'b0, 64'h7777);
    both(64'h2008, 1'b1, 1'b1, 64'h5000, 64'h2008, 1'b1, 64'h5000);
    lookup(64'h1000, 1'b1, 1'b0, 64'h3000);
    cyc();

    // reset mid-RUN with requests in flight, then requests held through INIT and a mid-INIT reset
    pc_valid = 1'b1; pc = 64'h1000;
    upd_valid = 1'b1; upd_pc = 64'h6000; upd_taken = 1'b1; upd_target = 64'h6666;
    reset = 1'b1;
    cyc();
    chk("run_reset_ready", 64'(ready), 64'd0);
    chk("run_reset_pred", 64'({pred_valid, pred_hit, pred_taken}), 64'd0);
    chk("run_reset_target", pred_target, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    chk("mid_init_ready", 64'(ready), 64'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_ready("reinit_cycles");
    pc_valid = 1'b0;
    upd_valid = 1'b0;
`ifdef BPU_BTB_PERF_EN
    chk("perf_lookup_clr", 64'(perf_lookup), 64'd0);
    chk("perf_hit_clr", 64'(perf_hit), 64'd0);
    chk("perf_alloc_clr", 64'(perf_alloc), 64'd0);
`endif
    lookup(64'h1000, 1'b0, 1'b0, 64'h0);
    lookup(64'h2008, 1'b0, 1'b0, 64'h0);
    lookup(64'h0C04, 1'b0, 1'b0, 64'h0);
    lookup(64'h6000, 1'b0, 1'b0, 64'h0);
    update(64'h1000, 1'b1, 64'h8000);
    lookup(64'h1000, 1'b1, 1'b1, 64'h8000);
`ifdef BPU_BTB_PERF_EN
    chk("perf_lookup", 64'(perf_lookup), 64'd5);
    chk("perf_hit", 64'(perf_hit), 64'd1);
    chk("perf_alloc", 64'(perf_alloc), 64'd1);
`endif
    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
